seven_seg_scan: RTL and testbench

Display stage directly downstream of the stopwatch counter: takes the four BCD digits (minutes tens/ones, seconds tens/ones) plus the adjust-mode controls and time-multiplexes them onto the board's 4-digit common-anode seven-segment display. It drives one digit at a time at a fixed scan rate, inserts an anode-off guard band at each digit change, lights the decimal point between minutes and seconds, and blinks the digit selected by `sel` while `adj` is high.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seven_seg_scan_if.sv | 23 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seven_seg_scan.sv | 116 +++++++++++
 tb/tb_seven_seg_scan.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display: active-low segment
// patterns (gfedcba), digit slot indices and the all-off values.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Slot order matches the sel encoding, rightmost digit first.
    localparam digit_idx_t IDX_SEC_ONES = 2'd0;
    localparam digit_idx_t IDX_SEC_TENS = 2'd1;
    localparam digit_idx_t IDX_MIN_ONES = 2'd2;
    localparam digit_idx_t IDX_MIN_TENS = 2'd3;

    // Active-low anode enable for a single digit slot.
    function automatic logic [3:0] an_select(input digit_idx_t idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Bundle between the stopwatch counter side (master) and the display
// scanner (slave): digit values and adjust controls in, display pins out.
interface seven_seg_scan_if;
    logic       adj;
    logic [1:0] sel;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output adj, sel, sec_ones, sec_tens, min_ones, min_tens,
        input  an, seg, dp
    );

    modport slave (
        input  adj, sel, sec_ones, sec_tens, min_ones, min_tens,
        output an, seg, dp
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup for one digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode display scanner. One digit per SCAN_DIV-cycle slot,
// anodes off for the first GUARD cycles of every slot to avoid ghosting, and
// the sel digit blinks at BLINK_DIV half-period while adj is high. Inputs are
// re-read every cycle; all pins are registered (one cycle latency).
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned GUARD     = 16,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input logic             clk_c,
    input logic             reset_c,
    seven_seg_scan_if.slave bus
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    digit_idx_t         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       scan_wrap;
    logic       blink_wrap;
    logic       in_guard;
    logic       blanked;

    assign scan_wrap  = (scan_cnt_q  == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign in_guard   = (scan_cnt_q  <  SCAN_W'(GUARD));
    // Blanking looks at live adj/sel so a release or reselect acts next cycle.
    assign blanked    = bus.adj && blink_ph_q && (idx_q == bus.sel);

    // Route the digit of the current slot to the single shared decoder.
    always_comb begin
        digit = bus.sec_ones;
        case (idx_q)
            IDX_SEC_ONES: digit = bus.sec_ones;
            IDX_SEC_TENS: digit = bus.sec_tens;
            IDX_MIN_ONES: digit = bus.min_ones;
            IDX_MIN_TENS: digit = bus.min_tens;
            default:      digit = bus.sec_ones;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    // Advance the slot timer and digit index; run the blink timer only in adjust mode.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end

        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!bus.adj) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_wrap) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Compose the next pin values from the current slot state.
    always_comb begin
        an_d = an_select(idx_q);
        if (in_guard || blanked) begin
            an_d = AN_OFF;
        end
        seg_d = digit_seg;
        dp_d  = (idx_q == IDX_MIN_ONES) ? 1'b0 : 1'b1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_c) begin
        if (reset_c) begin
            scan_cnt_q  <= '0;
            idx_q       <= IDX_SEC_ONES;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with small timing parameters. A cycle model
// produces the expected pins, pushed to a scoreboard queue before each edge
// and popped after it; scenarios add hand-derived spot checks.
module tb_seven_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int GUARD     = 1;
    localparam int BLINK_DIV = 8;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk_c = 1'b0;
    logic reset_c;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk_c   (clk_c),
        .reset_c (reset_c),
        .bus     (bus)
    );

    always #5 clk_c = ~clk_c;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_cnt, m_idx, m_bcnt;
    bit m_ph;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected pins after the coming edge, then advance the model one cycle.
    task automatic model_step(output exp_t e);
        logic [3:0] d;
        if (reset_c) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            m_cnt = 0; m_idx = 0; m_bcnt = 0; m_ph = 0;
            return;
        end
        case (m_idx)
            0: d = bus.sec_ones;
            1: d = bus.sec_tens;
            2: d = bus.min_ones;
            default: d = bus.min_tens;
        endcase
        e.seg = ref_seg(d);
        e.dp  = (m_idx == 2) ? 1'b0 : 1'b1;
        e.an  = 4'hF;
        if (!(m_cnt < GUARD || (bus.adj && m_ph && m_idx == int'(bus.sel))))
            e.an[m_idx] = 1'b0;
        m_cnt++;
        if (m_cnt == SCAN_DIV) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end
        if (!bus.adj) begin
            m_bcnt = 0; m_ph = 0;
        end else begin
            m_bcnt++;
            if (m_bcnt == BLINK_DIV) begin
                m_bcnt = 0; m_ph = !m_ph;
            end
        end
    endtask

    task automatic tick_push();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk_c); #1;
    endtask

    task automatic tick_discard();
        exp_t e;
        model_step(e);
        @(posedge clk_c); #1;
    endtask

    task automatic test_reset();
        exp_t e, got, dummy;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        reset_c = 1'b1;
        repeat (3) begin
            model_step(dummy);
            sb_q.push_back('{an: 4'hF, seg: 7'h7F, dp: 1'b1});
            @(posedge clk_c); #1;
            got = {bus.an, bus.seg, bus.dp};
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_hold: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
        reset_c = 1'b0;
        for (int c = 0; c < 32; c++) begin
            int slot = (c / 4) % 4;
            int pos  = c % 4;
            model_step(dummy);
            sb_q.push_back('{an: (pos == 0) ? 4'hF : an_tab[slot], seg: seg_tab[slot],
                             dp: (slot == 2) ? 1'b0 : 1'b1});
            @(posedge clk_c); #1;
            got = {bus.an, bus.seg, bus.dp};
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_frame c=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         c, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        exp_t e, got;
        int blank_seen = 0;
        bus.sec_ones = 4'hC;
        repeat (20) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (got.an == 4'b1110 && got.seg == 7'h7F) blank_seen++;
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL invalid_bcd: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
        checks++;
        if (blank_seen < 3) begin
            errors++;
            $display("FAIL invalid_bcd_slot0: blank lit cycles %0d, expected at least 3", blank_seen);
        end
        bus.sec_ones = 4'd4;
    endtask

    task automatic test_blink();
        exp_t e, got;
        int vis_a = 0, vis_b = 0;
        bit found = 0;
        bus.sel = 2'd1;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_idx == 1 && m_cnt == 2) found = 1;
            else tick_discard();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL blink_align: slot 1 position not reached, got none, expected within 64 cycles");
        end
        bus.adj = 1'b1;
        for (int c = 0; c < 48; c++) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (c < 8 && got.an == 4'b1101) vis_a++;
            if (c >= 8 && c < 16 && got.an == 4'b1101) vis_b++;
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL blink c=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         c, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
        checks++;
        if (vis_a != 2 || vis_b != 0) begin
            errors++;
            $display("FAIL blink_window: slot1 lit %0d/%0d, expected 2/0", vis_a, vis_b);
        end
        bus.sel = 2'd3;
        repeat (16) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL blink_sel_change: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_adj_release();
        exp_t e, got;
        bit found = 0;
        int blanks = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_ph && m_idx == int'(bus.sel) && m_cnt >= GUARD && m_cnt < SCAN_DIV - 1) found = 1;
            else tick_discard();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL release_align: blanked slot not reached, got none, expected within 64 cycles");
        end
        bus.adj = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (c == 0) begin
                checks++;
                if (got.an !== 4'b0111) begin
                    errors++;
                    $display("FAIL release_reappear: got an=%b, expected an=0111", got.an);
                end
            end
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL release: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
        bus.adj = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (c < 8 && got.an == 4'hF) blanks++;
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reraise c=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         c, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
        checks++;
        if (blanks != 2) begin
            errors++;
            $display("FAIL reraise_visible: off cycles in first 8 = %0d, expected 2 (guards only)", blanks);
        end
        bus.adj = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e, got;
        bit found = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_idx == 2 && m_cnt == 2) found = 1;
            else tick_discard();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_align: slot 2 not reached, got none, expected within 32 cycles");
        end
        reset_c = 1'b1;
        tick_push();
        reset_c = 1'b0;
        got = {bus.an, bus.seg, bus.dp};
        checks++;
        if (got !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL midreset_values: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1",
                     got.an, got.seg, got.dp);
        end
        e = sb_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL midreset: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     got.an, got.seg, got.dp, e.an, e.seg, e.dp);
        end
        for (int c = 0; c < 6; c++) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (c < 2) begin
                checks++;
                if (got.an !== ((c == 0) ? 4'b1111 : 4'b1110)) begin
                    errors++;
                    $display("FAIL midreset_restart c=%0d: got an=%b, expected an=%b",
                             c, got.an, (c == 0) ? 4'b1111 : 4'b1110);
                end
            end
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midreset_after: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_live_update();
        exp_t e, got;
        bit found = 0;
        bus.sec_ones = 4'd4;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_idx == 0 && m_cnt == 1) found = 1;
            else tick_discard();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL live_align: slot 0 not reached, got none, expected within 32 cycles");
        end
        bus.sec_ones = 4'd5;
        for (int c = 0; c < 8; c++) begin
            tick_push();
            got = {bus.an, bus.seg, bus.dp};
            if (c == 0) begin
                checks++;
                if (got.an !== 4'b1110 || got.seg !== 7'b0010010) begin
                    errors++;
                    $display("FAIL live_digit: got an=%b seg=%b, expected an=1110 seg=0010010",
                             got.an, got.seg);
                end
            end
            e = sb_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL live: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         got.an, got.seg, got.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        reset_c      = 1'b1;
        bus.adj      = 1'b0;
        bus.sel      = 2'd0;
        bus.min_tens = 4'd1;
        bus.min_ones = 4'd2;
        bus.sec_tens = 4'd3;
        bus.sec_ones = 4'd4;
        test_reset();
        test_invalid_bcd();
        test_blink();
        test_adj_release();
        test_mid_reset();
        test_live_update();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
